// File: rtl/boson_frame_writer.sv
// boson_frame_writer
//   Packs the resynchronised Boson pixel stream (16-bit pixels) into 32-bit words.
//   Buffers the words in a local FIFO.
//   Writes each frame to the HyperRAM frame buffer as wishbone incrementing bursts.
// Ports:
//   wb_clk_i, wb_rst_n_i     : wishbone clock, async active-low reset
//   enable_i                 : capture enable (level)
//   base_adr_i               : frame buffer byte address (word aligned)
//   frame_words_i            : 32-bit words per frame
//   s_data_i/s_valid_i/s_sof_i : pixel stream, no backpressure
//   m_wb_*                   : wishbone master (write-only, incrementing bursts)
//   frame_done_o             : one-cycle pulse after the ack of a frame's last word
//   overflow_o               : sticky, set when a packed word met a full FIFO
//   busy_o                   : master active or FIFO non-empty
module boson_frame_writer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic [31:0] base_adr_i,
  input  logic [23:0] frame_words_i,
  input  logic [15:0] s_data_i,
  input  logic        s_valid_i,
  input  logic        s_sof_i,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic [2:0]  m_wb_cti_o,
  output logic [1:0]  m_wb_bte_o,
  input  logic        m_wb_ack_i,
  output logic        frame_done_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  logic        in_frame_q, in_frame_d;
  logic        phase_q, phase_d;     // 1: next pixel is the odd (upper) half
  logic [15:0] half_q, half_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] cnt_inc;
  logic        first_q, first_d;
  logic        wv_q, wv_d;           // packed word waiting to be pushed
  logic [31:0] wd_q, wd_d;
  logic        wsof_q, wsof_d;
  logic        weof_q, weof_d;

  assign cnt_inc = cnt_q + 24'd1;

  always_comb begin
    in_frame_d = in_frame_q;
    phase_d    = phase_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    wv_d       = 1'b0;
    wd_d       = wd_q;
    wsof_d     = wsof_q;
    weof_d     = weof_q;
    if (!enable_i) begin
      in_frame_d = 1'b0;
    end else if (s_valid_i) begin
      if (s_sof_i) begin
        // A sof always restarts, dropping any pending half word.
        in_frame_d = (frame_words_i != 24'd0);
        phase_d    = 1'b1;
        half_d     = s_data_i;
        cnt_d      = '0;
        first_d    = 1'b1;
      end else if (in_frame_q) begin
        if (!phase_q) begin
          half_d  = s_data_i;
          phase_d = 1'b1;
        end else begin
          wv_d    = 1'b1;
          wd_d    = {s_data_i, half_q};
          wsof_d  = first_q;
          weof_d  = (cnt_inc == frame_words_i);
          cnt_d   = cnt_inc;
          first_d = 1'b0;
          phase_d = 1'b0;
          if (cnt_inc == frame_words_i) in_frame_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      in_frame_q <= 1'b0;
      phase_q    <= 1'b0;
      half_q     <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      wv_q       <= 1'b0;
      wd_q       <= '0;
      wsof_q     <= 1'b0;
      weof_q     <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      phase_q    <= phase_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      wv_q       <= wv_d;
      wd_q       <= wd_d;
      wsof_q     <= wsof_d;
      weof_q     <= weof_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_dat [FIFO_DEPTH];
  logic          mem_sof [FIFO_DEPTH];
  logic          mem_eof [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] eof_cnt_q;          // eof entries currently held
  logic          full, push_req, push, pop, flush;
  logic          ovf_q;
  logic [31:0]   head_dat;
  logic          head_sof, head_eof;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [31:0]   adr_q, adr_d;
  logic [BW-1:0] left_q, left_d;
  logic          done_q, done_d;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign push_req = wv_q & enable_i;
  assign push     = push_req & ~full;   // full is judged before any same-cycle pop
  assign pop      = cyc_q & m_wb_ack_i;
  assign flush    = (state_q == StIdle) & ~enable_i;
  assign head_dat = mem_dat[rptr_q];
  assign head_sof = mem_sof[rptr_q];
  assign head_eof = mem_eof[rptr_q];

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_dat[wptr_q] <= wd_q;
      mem_sof[wptr_q] <= wsof_q;
      mem_eof[wptr_q] <= weof_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      eof_cnt_q <= '0;
    end else if (flush) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      eof_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_q + AW'(push);
      rptr_q    <= rptr_q + AW'(pop);
      level_q   <= level_q + LW'(push) - LW'(pop);
      eof_cnt_q <= eof_cnt_q + LW'(push & weof_q) - LW'(pop & head_eof);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (!enable_i) begin
      ovf_q <= 1'b0;
    end else if (push_req && full) begin
      ovf_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst sizing: min(level, BURST_LEN), cut before any later sof entry so a
  // new frame always opens its own burst at base_adr_i.
  // ---------------------------------------------------------------------------
  logic [BW-1:0] n_lim, burst_n;
  logic          start;

  always_comb begin
    n_lim = (level_q >= LW'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(level_q);
    burst_n = n_lim;
    for (int i = int'(BURST_LEN) - 1; i >= 1; i--) begin
      if ((BW'(i) < n_lim) && mem_sof[rptr_q + AW'(i)]) burst_n = BW'(i);
    end
  end

  assign start = enable_i & ((level_q >= LW'(BURST_LEN)) | (eof_cnt_q != '0));

  // ---------------------------------------------------------------------------
  // Master FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    left_d  = left_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBurst;
          cyc_d   = 1'b1;
          left_d  = burst_n;
          if (head_sof) adr_d = base_adr_i;
        end
      end
      StBurst: begin
        if (pop) begin
          adr_d  = adr_q + 32'd4;
          left_d = left_q - BW'(1);
          done_d = head_eof;
          if (left_q == BW'(1)) begin
            cyc_d   = 1'b0;
            state_d = StGap;
          end
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  assign m_wb_adr_o   = adr_q;
  assign m_wb_dat_o   = cyc_q ? head_dat : 32'd0;
  assign m_wb_sel_o   = 4'hF;
  assign m_wb_we_o    = 1'b1;
  assign m_wb_cyc_o   = cyc_q;
  assign m_wb_stb_o   = cyc_q;
  assign m_wb_cti_o   = !cyc_q ? 3'b000 : ((left_q == BW'(1)) ? 3'b111 : 3'b010);
  assign m_wb_bte_o   = 2'b00;
  assign frame_done_o = done_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != StIdle) | (level_q != '0);

endmodule
